// File: rtl/axis_constant_burst.sv
// Double-buffered multi-channel constant AXI4-Stream source with continuous and counted burst modes.
// Define AXIS_CONSTANT_RAMP_EN to add cfg_step and a per-channel increment after every transfer.
module axis_constant_burst #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CHANNELS         = 2,
    parameter int unsigned CNT_WIDTH        = 32
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] cfg_data,
`ifdef AXIS_CONSTANT_RAMP_EN
    input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] cfg_step,
`endif
    input  logic                                 cfg_load,
    input  logic                                 cfg_mode,
    input  logic [CNT_WIDTH-1:0]                 cfg_count,
    input  logic                                 start,
    input  logic                                 stop,
    output logic                                 busy,
    output logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast
);

    localparam int unsigned DW = CHANNELS * AXIS_TDATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [DW-1:0]          r_shadow;
    logic [DW-1:0]          r_active;
    logic [DW-1:0]          w_active_next;
    logic                   r_reload_pend;
    logic                   r_mode;
    logic                   w_mode_next;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic                   r_stop_pend;
    logic                   w_stop_pend_next;
    logic                   r_tvalid;
    logic                   w_tvalid_next;
    logic                   r_tlast;
    logic                   w_tlast_next;
    logic                   w_xfer;
    logic                   w_slot_free;
    logic                   w_start_ok;

    assign w_xfer      = r_tvalid && m_axis_tready;
    assign w_slot_free = !r_tvalid || m_axis_tready;
    assign w_start_ok  = start && (!cfg_mode || (cfg_count != '0));

`ifdef AXIS_CONSTANT_RAMP_EN
    logic [DW-1:0] r_step;
    logic [DW-1:0] w_ramp;

    always_comb begin
        w_ramp = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_ramp[c*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] =
                r_active[c*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] +
                r_step[c*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_step <= '0;
        end else if (cfg_load) begin
            r_step <= cfg_step;
        end
    end
`endif

    // A pending reload always beats the ramp increment on the same edge.
    always_comb begin
        w_active_next = r_active;
`ifdef AXIS_CONSTANT_RAMP_EN
        if (w_xfer) begin
            w_active_next = w_ramp;
        end
`endif
        if (w_slot_free && r_reload_pend) begin
            w_active_next = r_shadow;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_reload_pend <= 1'b0;
        end else begin
            r_active <= w_active_next;
            if (cfg_load) begin
                r_shadow      <= cfg_data;
                r_reload_pend <= 1'b1;
            end else if (w_slot_free) begin
                r_reload_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_mode_next      = r_mode;
        w_count_next     = r_count;
        w_stop_pend_next = r_stop_pend;
        w_tvalid_next    = r_tvalid;
        w_tlast_next     = r_tlast;
        unique case (r_state)
            StIdle: begin
                w_tvalid_next    = 1'b0;
                w_tlast_next     = 1'b0;
                w_stop_pend_next = 1'b0;
                // start wins over a coincident stop, so stop is simply not looked at here
                if (w_start_ok) begin
                    w_state_next  = StRun;
                    w_mode_next   = cfg_mode;
                    w_count_next  = cfg_mode ? cfg_count : '0;
                    w_tvalid_next = 1'b1;
                    w_tlast_next  = cfg_mode && (cfg_count == CntOne);
                end
            end
            StRun: begin
                if (!r_mode) begin
                    w_tlast_next = 1'b0;
                    if (stop) begin
                        w_stop_pend_next = 1'b1;
                    end
                    if ((r_stop_pend && w_xfer) || (!r_tvalid && (r_stop_pend || stop))) begin
                        w_state_next     = StIdle;
                        w_tvalid_next    = 1'b0;
                        w_stop_pend_next = 1'b0;
                    end else begin
                        w_tvalid_next = 1'b1;
                    end
                end else if (w_xfer && r_tlast) begin
                    w_state_next     = StIdle;
                    w_tvalid_next    = 1'b0;
                    w_tlast_next     = 1'b0;
                    w_count_next     = '0;
                    w_stop_pend_next = 1'b0;
                end else if (w_xfer) begin
                    w_count_next     = r_count - CntOne;
                    w_stop_pend_next = r_stop_pend || stop;
                    w_tlast_next     = ((r_count - CntOne) == CntOne) || r_stop_pend || stop;
                end else begin
                    // Held beat: tlast may only rise, and only because of stop.
                    w_stop_pend_next = r_stop_pend || stop;
                    w_tlast_next     = r_tlast || stop;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= StIdle;
            r_mode      <= 1'b0;
            r_count     <= '0;
            r_stop_pend <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mode      <= w_mode_next;
            r_count     <= w_count_next;
            r_stop_pend <= w_stop_pend_next;
            r_tvalid    <= w_tvalid_next;
            r_tlast     <= w_tlast_next;
        end
    end

    assign busy          = (r_state == StRun);
    assign m_axis_tdata  = r_active;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

endmodule

// File: doc/axis_constant_burst.md
Name: axis_constant_burst

Overview:
Parametrised, multi-channel successor to the free-running constant AXI4-Stream source. Holds CHANNELS constant words in a double-buffered register and emits them on a real AXI4-Stream master with tready backpressure. Supports a continuous mode and a counted burst mode with tlast. Sits between the PS config registers and DSP/DAC stream consumers; used for DC offsets, test patterns and calibration bursts.

Parameters:
AXIS_TDATA_WIDTH, 32, width of one channel word
CHANNELS, 2, number of channel words packed into m_axis_tdata; channel 0 in the LSBs
CNT_WIDTH, 32, width of burst beat counter

Ports:
aclk  input  1  system clock; all logic on rising edge
areset  input  1  asynchronous, active-high reset
cfg_data  input  CHANNELS*AXIS_TDATA_WIDTH  new constant words
cfg_load  input  1  one-cycle strobe: capture cfg_data into shadow register
cfg_mode  input  1  0 = continuous, 1 = burst; sampled on accepted start
cfg_count  input  CNT_WIDTH  burst length in beats; sampled on accepted start
start  input  1  one-cycle strobe: begin streaming
stop  input  1  one-cycle strobe: end streaming at next beat boundary
busy  output  1  high while state is RUN
m_axis_tdata  output  CHANNELS*AXIS_TDATA_WIDTH  active constant words
m_axis_tvalid  output  1  beat valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  last beat of burst

Behaviour:
- Reset (async assert, sync release): state IDLE, shadow = 0, active = 0, m_axis_tvalid = 0, m_axis_tlast = 0, busy = 0, counter = 0.
- Handshake: a beat transfers when tvalid && tready. Once tvalid is high, tdata, tlast and tvalid hold until transfer; stop never drops tvalid mid-beat.
- Double buffer: cfg_load writes shadow on the same edge, in any state. Active is reloaded from shadow when "slot free" = !tvalid || tready. A cfg_load at edge N appears on tdata at N+1 if the slot is free at N+1, otherwise at the first beat after the pending transfer. tdata = active register, registered output.
- States:
  IDLE: tvalid = 0. Accept start when cfg_mode = 0, or cfg_mode = 1 with cfg_count != 0. Latch mode and count, go RUN, assert tvalid next cycle (start-to-tvalid latency 1). Burst start with cfg_count = 0 is ignored (stay IDLE, busy = 0).
  RUN, continuous: tvalid held high; tlast = 0 always. stop latches stop_pending. On the next transfer (or immediately if tvalid is low), go IDLE, tvalid = 0.
  RUN, burst: counter = beats remaining. Decrement on each transfer. tlast = 1 exactly while counter == 1. Transfer with counter == 1 goes to IDLE. stop makes the next transfer the last: tlast asserted on the beat presented after stop's edge. If that beat is already valid, tlast rises on it while tvalid stays high; this is the one permitted change of a held sideband signal.
- start while RUN: ignored. start and stop on the same cycle in IDLE: start wins, stop ignored.
- cfg_count = 1: single beat with tlast = 1. cfg_count = max value: counts fully, no wrap.
- areset mid-burst: immediate return to reset values; no partial tlast.

Optional Feature:
AXIS_CONSTANT_RAMP_EN
- Defined: extra input cfg_step [CHANNELS*AXIS_TDATA_WIDTH], latched with cfg_load. After each transfer, each channel's active word += its step, modulo 2^AXIS_TDATA_WIDTH, no carry between channels. cfg_load reload overrides the increment on the same edge. Reset clears the step.
- Undefined: port absent; active changes only via shadow reload.

Test Plan:
- Reset, then cfg_load 0x0000_0005/0x0000_000A, burst start count=4, tready=1 -> 4 beats tdata=0x0000000A_00000005, tlast on beat 4 only, busy low cycle after.
- Burst count=3, tready toggled 1,0,0,1,1 -> tdata/tlast stable during stalls, exactly 3 transfers, tlast on the 3rd transfer.
- Continuous mode, tready=1, cfg_load new value mid-stream -> new value on tdata the cycle after load. Stop with tready=0 -> tvalid held until transfer, then 0.
- Burst count=0 start -> busy stays 0, tvalid stays 0. Burst count=1 -> one beat with tlast=1.
- areset asserted mid-burst with tvalid=1, tready=0 -> tvalid, tlast, busy and tdata drop to 0 without waiting for a clock edge.
- RAMP_EN: data=0xFFFFFFFE, step=1, count=3 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on channel 0.
